homenc_instr_sequencer: RTL and testbench
=========================================

HOMENC_INSTR_SEQUENCER -- requirements
Module: homenc_instr_sequencer

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 16, command queue depth; power of two, 2..256.
REQ-002 SHALL have parameter GAP_CYCLES, default 2, idle cycles (instruction 0) driven before each command; minimum 1.
REQ-003 SHALL have parameter DONE_MASK, default 4, cycles after issue during which cp_done is ignored; minimum 1.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 1048576, maximum cycles spent waiting for cp_done.
REQ-005 SHALL have port clk  input  1  single clock; all logic rising-edge.
REQ-006 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-007 SHALL have port cmd_valid  input  1  host command valid.
REQ-008 SHALL have port cmd_data  input  25  {wtM1[24:21], wtM0[20:17], rdM1[16:13], rdM0[12:9], modulus_sel[8], instruction[7:0]}.
REQ-009 SHALL have port cmd_ready  output  1  queue can accept a command.
REQ-010 SHALL have ports instruction (output, 8), modulus_sel (output, 1), rdM0/rdM1/wtM0/wtM1 (output, 4 each): registered command fields to the coprocessor.
REQ-011 SHALL have port cp_done  input  1  coprocessor done level.
REQ-012 SHALL have port busy  output  1  high when the queue is non-empty or the FSM is not IDLE.
REQ-013 SHALL have port fifo_level  output  $clog2(FIFO_DEPTH)+1  number of queued commands.
REQ-014 SHALL have port cmd_done_pulse  output  1  one-cycle pulse per completed command.
REQ-015 SHALL have port done_count  output  16  completed-command counter.
REQ-016 SHALL have ports timeout_err (output, 1, sticky timeout flag) and err_clr (input, 1, clears timeout_err).

Function
REQ-017 SHALL accept a command on each cycle with cmd_valid && cmd_ready, writing it into the FIFO tail.
REQ-018 SHALL drive cmd_ready = (fifo_level < FIFO_DEPTH); when full, a pop in the same cycle SHALL NOT raise cmd_ready that cycle, and no entry is overwritten.
REQ-019 SHALL implement FSM states IDLE, GAP, ISSUE, WAIT, COMPLETE.
REQ-020 IDLE: drive all command outputs 0; if FIFO non-empty, pop head into holding register; instruction field 0 -> COMPLETE, else -> GAP.
REQ-021 GAP: drive outputs 0 for exactly GAP_CYCLES cycles, then -> ISSUE.
REQ-022 ISSUE: drive held fields on outputs; ignore cp_done for DONE_MASK cycles, then -> WAIT.
REQ-023 WAIT: hold fields; cp_done=1 -> COMPLETE; after TIMEOUT_CYCLES cycles in WAIT without cp_done -> set timeout_err, -> IDLE, no pulse, no count increment.
REQ-024 COMPLETE: one cycle; outputs 0, cmd_done_pulse=1, done_count+1 (0xFFFF wraps to 0x0000); -> IDLE.
REQ-025 Latency: command accepted in cycle c into an empty FIFO while IDLE SHALL make instruction non-zero in cycle c+GAP_CYCLES+2.
REQ-026 Back-to-back: each command SHALL be separated from the previous by at least COMPLETE + IDLE + GAP_CYCLES cycles of instruction 0.
REQ-027 Simultaneous push and pop on a non-full, non-empty FIFO SHALL leave fifo_level unchanged; pop from an empty FIFO SHALL NOT occur.
REQ-028 err_clr SHALL clear timeout_err next edge; a timeout in the same cycle SHALL win (flag stays 1).
REQ-029 All outputs SHALL be registered; no combinational path from cp_done to any output.

Reset
REQ-030 On rst=1 at a clock edge: FSM=IDLE, FIFO empty, fifo_level=0, command outputs 0, cmd_done_pulse=0, done_count=0, timeout_err=0, busy=0.
REQ-031 rst mid-command SHALL force instruction=0 at the next edge and discard all queued and in-flight commands; cmd_ready=1 the cycle after reset deasserts.

Verification
REQ-032 Single command 0x0A_5 fields (instruction=5, rdM0=3, wtM0=7), cp_done asserted 20 cycles after issue -> instruction=5 in cycle c+4, one cmd_done_pulse, done_count=1, instruction back to 0.
REQ-033 Push 17 commands with no completions (FIFO_DEPTH=16) -> cmd_ready low after 16 queued plus 1 popped, no loss; all 17 complete in order, done_count=17.
REQ-034 cp_done held high from before issue -> ignored for DONE_MASK=4 cycles, completion in cycle 5 of ISSUE/WAIT, not earlier.
REQ-035 cp_done never asserted with TIMEOUT_CYCLES=100 -> timeout_err=1 after 100 WAIT cycles, next queued command still issues; err_clr then clears flag.
REQ-036 Command with instruction=0 -> completes via COMPLETE without GAP/ISSUE, pulse and count increment, outputs stay 0.
REQ-037 rst asserted during WAIT with 3 queued -> next cycle instruction=0, fifo_level=0, done_count=0, busy=0.

Source files
------------

// File: rtl/homenc_instr_sequencer.sv
// homenc_instr_sequencer: queues host commands and sequences them to the coprocessor with gap, done-mask and timeout handling
module homenc_instr_sequencer #(
  parameter int FIFO_DEPTH = 16,
  parameter int GAP_CYCLES = 2,
  parameter int DONE_MASK = 4,
  parameter int TIMEOUT_CYCLES = 1048576
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          cmd_valid,
  input  logic [24:0]                   cmd_data,
  output logic                          cmd_ready,
  output logic [7:0]                    instruction,
  output logic                          modulus_sel,
  output logic [3:0]                    rdM0,
  output logic [3:0]                    rdM1,
  output logic [3:0]                    wtM0,
  output logic [3:0]                    wtM1,
  input  logic                          cp_done,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          cmd_done_pulse,
  output logic [15:0]                   done_count,
  output logic                          timeout_err,
  input  logic                          err_clr
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_GAP = 3'd1;
  localparam logic [2:0] S_ISSUE = 3'd2;
  localparam logic [2:0] S_WAIT = 3'd3;
  localparam logic [2:0] S_COMPLETE = 3'd4;
  logic [24:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [2:0] state, nstate;
  logic [24:0] hold, head;
  logic [31:0] cnt;
  logic push, pop, timeout, drive;
  assign cmd_ready = fifo_level < LW'(FIFO_DEPTH);
  assign busy = (fifo_level != '0) || (state != S_IDLE);
  assign push = cmd_valid && cmd_ready;
  assign pop = (state == S_IDLE) && (fifo_level != '0);
  assign head = mem[rd_ptr];
  assign drive = (nstate == S_ISSUE) || (nstate == S_WAIT);
  always_comb begin
    nstate = state;
    timeout = 1'b0;
    case (state)
      S_IDLE: if (pop) nstate = (head[7:0] == 8'd0) ? S_COMPLETE : S_GAP;
      S_GAP: if (cnt == 32'(GAP_CYCLES - 1)) nstate = S_ISSUE;
      S_ISSUE: if (cnt == 32'(DONE_MASK - 1)) nstate = S_WAIT;
      S_WAIT: begin
        if (cp_done) nstate = S_COMPLETE;
        else if (cnt == 32'(TIMEOUT_CYCLES - 1)) begin
          nstate = S_IDLE;
          timeout = 1'b1;
        end
      end
      S_COMPLETE: nstate = S_IDLE;
      default: nstate = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) if (push) mem[wr_ptr] <= cmd_data;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      cnt <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      fifo_level <= '0;
      hold <= '0;
      {wtM1, wtM0, rdM1, rdM0, modulus_sel, instruction} <= '0;
      cmd_done_pulse <= 1'b0;
      done_count <= '0;
      timeout_err <= 1'b0;
    end else begin
      state <= nstate;
      cnt <= (nstate != state) ? '0 : cnt + 32'd1;
      wr_ptr <= push ? wr_ptr + AW'(1) : wr_ptr;
      rd_ptr <= pop ? rd_ptr + AW'(1) : rd_ptr;
      fifo_level <= fifo_level + LW'(push) - LW'(pop);
      hold <= pop ? head : hold;
      {wtM1, wtM0, rdM1, rdM0, modulus_sel, instruction} <= drive ? hold : '0;
      cmd_done_pulse <= nstate == S_COMPLETE;
      done_count <= done_count + 16'(nstate == S_COMPLETE);
      timeout_err <= timeout ? 1'b1 : err_clr ? 1'b0 : timeout_err;
    end
  end
endmodule

// File: tb/tb_homenc_instr_sequencer.sv
// tb_homenc_instr_sequencer: directed self-checking bench for the instruction sequencer
module tb_homenc_instr_sequencer;
  logic clk = 1'b0;
  logic rst, cmd_valid, cp_done, err_clr;
  logic [24:0] cmd_data;
  logic cmd_ready, modulus_sel, busy, cmd_done_pulse, timeout_err;
  logic [7:0] instruction;
  logic [3:0] rdM0, rdM1, wtM0, wtM1;
  logic [4:0] fifo_level;
  logic [15:0] done_count;
  int errors = 0;
  int checks = 0;
  typedef struct {
    logic [24:0] cmd;
    int delay;
    logic [7:0] ins;
    logic msel;
    logic [3:0] r0, r1, w0, w1;
    logic [15:0] cnt;
  } vec_t;
  vec_t vecs [3];
  homenc_instr_sequencer #(.FIFO_DEPTH(16), .GAP_CYCLES(2), .DONE_MASK(4), .TIMEOUT_CYCLES(100)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_data(cmd_data), .cmd_ready(cmd_ready),
    .instruction(instruction), .modulus_sel(modulus_sel), .rdM0(rdM0), .rdM1(rdM1), .wtM0(wtM0), .wtM1(wtM1),
    .cp_done(cp_done), .busy(busy), .fifo_level(fifo_level), .cmd_done_pulse(cmd_done_pulse),
    .done_count(done_count), .timeout_err(timeout_err), .err_clr(err_clr)
  );
  always #5 clk = ~clk;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic push(input logic [24:0] d);
    cmd_valid = 1'b1;
    cmd_data = d;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask
  task automatic wait_nz(input string name);
    int n = 0;
    while (instruction == 8'd0 && n < 300) begin
      n++;
      @(negedge clk);
    end
    check(name, 32'(instruction != 8'd0), 32'd1);
  endtask
  task automatic wait_pulse(input string name);
    int n = 0;
    while (!cmd_done_pulse && n < 300) begin
      n++;
      @(negedge clk);
    end
    check(name, 32'(cmd_done_pulse), 32'd1);
  endtask
  task automatic count_nz(output int n);
    n = 0;
    while (instruction != 8'd0 && n < 300) begin
      n++;
      @(negedge clk);
    end
  endtask
  initial begin
    int n;
    vecs[0] = '{{4'h0, 4'h7, 4'h0, 4'h3, 1'b0, 8'h05}, 20, 8'h05, 1'b0, 4'h3, 4'h0, 4'h7, 4'h0, 16'd2};
    vecs[1] = '{{4'hF, 4'h1, 4'h2, 4'h4, 1'b1, 8'h81}, 3, 8'h81, 1'b1, 4'h4, 4'h2, 4'h1, 4'hF, 16'd3};
    vecs[2] = '{{4'hA, 4'h5, 4'hC, 4'h3, 1'b0, 8'hFF}, 0, 8'hFF, 1'b0, 4'h3, 4'hC, 4'h5, 4'hA, 16'd4};
    rst = 1'b1; cmd_valid = 1'b0; cmd_data = '0; cp_done = 1'b0; err_clr = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_instr", 32'(instruction), 0);
    check("rst_level", 32'(fifo_level), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_count", 32'(done_count), 0);
    check("rst_err", 32'(timeout_err), 0);
    check("rst_pulse", 32'(cmd_done_pulse), 0);
    rst = 1'b0;
    @(negedge clk);
    check("rst_ready", 32'(cmd_ready), 1);
    push(25'h00E0605);
    check("lat_c1", 32'(instruction), 0);
    @(negedge clk);
    check("lat_c2", 32'(instruction), 0);
    @(negedge clk);
    check("lat_c3", 32'(instruction), 0);
    @(negedge clk);
    check("lat_c4", 32'(instruction), 5);
    check("lat_fields", 32'({wtM0, rdM0}), 32'h73);
    repeat (20) @(negedge clk);
    cp_done = 1'b1;
    wait_pulse("single_pulse");
    cp_done = 1'b0;
    check("single_count", 32'(done_count), 1);
    check("single_instr0", 32'(instruction), 0);
    @(negedge clk);
    check("single_pulse_width", 32'(cmd_done_pulse), 0);
    for (int i = 0; i < 3; i++) begin
      push(vecs[i].cmd);
      wait_nz("vec_issue");
      check("vec_instr", 32'(instruction), 32'(vecs[i].ins));
      check("vec_msel", 32'(modulus_sel), 32'(vecs[i].msel));
      check("vec_rd", 32'({rdM1, rdM0}), 32'({vecs[i].r1, vecs[i].r0}));
      check("vec_wt", 32'({wtM1, wtM0}), 32'({vecs[i].w1, vecs[i].w0}));
      repeat (vecs[i].delay) @(negedge clk);
      cp_done = 1'b1;
      wait_pulse("vec_pulse");
      cp_done = 1'b0;
      check("vec_count", 32'(done_count), 32'(vecs[i].cnt));
    end
    cp_done = 1'b1;
    push({4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 8'h42});
    wait_nz("mask_issue");
    count_nz(n);
    check("mask_len", 32'(n), 5);
    check("mask_pulse", 32'(cmd_done_pulse), 1);
    check("mask_count", 32'(done_count), 5);
    cp_done = 1'b0;
    @(negedge clk);
    push({4'h3, 4'h3, 4'h3, 4'h3, 1'b1, 8'h00});
    check("zero_pulse_c1", 32'(cmd_done_pulse), 0);
    @(negedge clk);
    check("zero_pulse_c2", 32'(cmd_done_pulse), 1);
    check("zero_outs", 32'({wtM1, wtM0, rdM1, rdM0, modulus_sel, instruction}), 0);
    check("zero_count", 32'(done_count), 6);
    @(negedge clk);
    check("zero_pulse_c3", 32'(cmd_done_pulse), 0);
    push({4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 8'h11});
    push({4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 8'h22});
    wait_nz("to_issue");
    check("to_first", 32'(instruction), 32'h11);
    count_nz(n);
    check("to_len", 32'(n), 104);
    check("to_err", 32'(timeout_err), 1);
    check("to_nopulse", 32'(cmd_done_pulse), 0);
    check("to_count", 32'(done_count), 6);
    wait_nz("to_next_issue");
    check("to_next", 32'(instruction), 32'h22);
    check("to_err_sticky", 32'(timeout_err), 1);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    check("to_err_clr", 32'(timeout_err), 0);
    cp_done = 1'b1;
    wait_pulse("to_next_pulse");
    cp_done = 1'b0;
    check("to_next_count", 32'(done_count), 7);
    @(negedge clk);
    for (int i = 0; i < 17; i++) push({4'h0, 4'(i), 4'h0, 4'h0, 1'b0, 8'(i + 1)});
    check("full_ready", 32'(cmd_ready), 0);
    check("full_level", 32'(fifo_level), 16);
    push({4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 8'h55});
    check("full_no_overwrite", 32'(fifo_level), 16);
    for (int i = 0; i < 17; i++) begin
      wait_nz("full_issue");
      check("full_order", 32'({wtM0, instruction}), 32'({4'(i), 8'(i + 1)}));
      cp_done = 1'b1;
      wait_pulse("full_pulse");
      cp_done = 1'b0;
    end
    check("full_count", 32'(done_count), 24);
    @(negedge clk);
    check("full_drained", 32'({busy, fifo_level}), 0);
    for (int i = 0; i < 4; i++) push({4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 8'(8'h60 + i)});
    wait_nz("rst_mid_issue");
    repeat (6) @(negedge clk);
    check("rst_mid_level", 32'(fifo_level), 3);
    check("rst_mid_instr", 32'(instruction), 32'h60);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_instr0", 32'(instruction), 0);
    check("rst_mid_level0", 32'(fifo_level), 0);
    check("rst_mid_count0", 32'(done_count), 0);
    check("rst_mid_busy0", 32'(busy), 0);
    rst = 1'b0;
    @(negedge clk);
    check("rst_mid_ready", 32'(cmd_ready), 1);
    repeat (5) @(negedge clk);
    check("rst_mid_quiet", 32'({busy, instruction}), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
